mc_core_datapath: RTL

Parametrised multicycle datapath with an integrated state sequencer, replacing the fixed-width datapath that depends on an external controller and single-cycle memories. Each instruction steps through FETCH/DECODE/EXEC/MEM/WB states. Instruction and data memories sit behind variable-latency req/ack handshakes. The block sits between the instruction/data memory subsystems and the top-level CPU wrapper.

---
 rtl/mc_core_pkg.sv | 35 +++
 rtl/mc_core_datapath_if.sv | 29 ++
 rtl/mc_regfile.sv | 34 +++
 rtl/mc_core_datapath.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/mc_core_pkg.sv
// mc_core_pkg: shared constants for the multicycle core datapath.
//   - opcode values (instruction bits [31:26])
//   - instruction field positions
//   - sequencer state encoding
package mc_core_pkg;

  localparam int unsigned InstrW = 32;

  // Field least-significant-bit positions inside the 32-bit instruction word.
  localparam int unsigned OpLsb = 26;
  localparam int unsigned R1Lsb = 21;
  localparam int unsigned R2Lsb = 16;
  localparam int unsigned R3Lsb = 11;

  localparam logic [5:0] OpAdd  = 6'h01;
  localparam logic [5:0] OpSub  = 6'h02;
  localparam logic [5:0] OpAnd  = 6'h03;
  localparam logic [5:0] OpOr   = 6'h04;
  localparam logic [5:0] OpAddi = 6'h05;
  localparam logic [5:0] OpLd   = 6'h06;
  localparam logic [5:0] OpSt   = 6'h07;
  localparam logic [5:0] OpBeq  = 6'h08;
  localparam logic [5:0] OpJ    = 6'h09;
  localparam logic [5:0] OpHalt = 6'h3F;

  typedef enum logic [2:0] {
    StFetch  = 3'd0,
    StDecode = 3'd1,
    StExec   = 3'd2,
    StMem    = 3'd3,
    StWb     = 3'd4,
    StHalt   = 3'd5
  } state_e;

endpackage

// File: rtl/mc_core_datapath_if.sv
// mc_core_datapath_if: instruction- and data-memory req/ack handshake bundle.
//   master: the core (drives requests, receives ack/rdata)
//   slave : the memory subsystem
interface mc_core_datapath_if #(
  parameter int unsigned PC_W    = 16,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned DADDR_W = 16
);
  logic               imem_req;
  logic [PC_W-1:0]    imem_addr;
  logic               imem_ack;
  logic [31:0]        imem_rdata;
  logic               dmem_req;
  logic               dmem_we;
  logic [DADDR_W-1:0] dmem_addr;
  logic [DATA_W-1:0]  dmem_wdata;
  logic               dmem_ack;
  logic [DATA_W-1:0]  dmem_rdata;

  modport master (
    output imem_req, imem_addr, dmem_req, dmem_we, dmem_addr, dmem_wdata,
    input  imem_ack, imem_rdata, dmem_ack, dmem_rdata
  );

  modport slave (
    input  imem_req, imem_addr, dmem_req, dmem_we, dmem_addr, dmem_wdata,
    output imem_ack, imem_rdata, dmem_ack, dmem_rdata
  );
endinterface

// File: rtl/mc_regfile.sv
// mc_regfile: 2^AW x DATA_W register file.
//   clk_i, rst_i          clock, asynchronous active-high reset (clears all registers)
//   raddr_a_i/rdata_a_o   asynchronous read port A
//   raddr_b_i/rdata_b_o   asynchronous read port B
//   we_i/waddr_i/wdata_i  synchronous write port; writes to register 0 are dropped
module mc_regfile #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned AW     = 5
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [AW-1:0]     raddr_a_i,
  output logic [DATA_W-1:0] rdata_a_o,
  input  logic [AW-1:0]     raddr_b_i,
  output logic [DATA_W-1:0] rdata_b_o,
  input  logic              we_i,
  input  logic [AW-1:0]     waddr_i,
  input  logic [DATA_W-1:0] wdata_i
);
  localparam int unsigned NumRegs = 1 << AW;

  logic [DATA_W-1:0] regs_q [NumRegs];

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < NumRegs; i++) regs_q[i] <= '0;
    end else if (we_i && (waddr_i != '0)) begin
      regs_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_a_o = (raddr_a_i == '0) ? '0 : regs_q[raddr_a_i];
  assign rdata_b_o = (raddr_b_i == '0) ? '0 : regs_q[raddr_b_i];
endmodule

// File: rtl/mc_core_datapath.sv
// mc_core_datapath: multicycle datapath with integrated FETCH/DECODE/EXEC/MEM/WB sequencer.
//   clk, reset  clock, asynchronous active-high reset
//   bus         memory handshakes (master side): imem req/addr/ack/rdata, dmem req/we/addr/
//               wdata/ack/rdata; all request-side signals come straight from flops
//   halted      HALT has executed (sticky until reset)
//   pc          current program counter (word address)
//   state       sequencer state, debug only
module mc_core_datapath
  import mc_core_pkg::*;
#(
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned REG_AW  = 5,
  parameter int unsigned PC_W    = 16,
  parameter int unsigned DADDR_W = 16
) (
  input  logic            clk,
  input  logic            reset,
  mc_core_datapath_if.master bus,
  output logic            halted,
  output logic [PC_W-1:0] pc,
  output logic [2:0]      state
);
  state_e              state_q, state_d;
  logic [PC_W-1:0]     pc_q, pc_d, pc_inc;
  logic [InstrW-1:0]   ir_q, ir_d;
  logic [DATA_W-1:0]   a_q, a_d, b_q, b_d, alu_q, alu_d, mdr_q, mdr_d;
  logic                imem_req_q, imem_req_d;
  logic                dmem_req_q, dmem_req_d;
  logic                dmem_we_q, dmem_we_d;

  logic [5:0]          op;
  logic [REG_AW-1:0]   r1, r2, r3, raddr_a, raddr_b;
  logic [DATA_W-1:0]   imm_sext, rdata_a, rdata_b, rf_wdata;
  logic                rf_we;

  assign op       = ir_q[OpLsb +: 6];
  assign r1       = ir_q[R1Lsb +: REG_AW];
  assign r2       = ir_q[R2Lsb +: REG_AW];
  assign r3       = ir_q[R3Lsb +: REG_AW];
  assign imm_sext = DATA_W'($signed(ir_q[15:0]));
  assign pc_inc   = pc_q + PC_W'(1);

  // A carries the base/first operand, B the second operand or store data.
  // BEQ compares r1 with r2; ST uses r2 as base and r1 as data.
  assign raddr_a = (op == OpBeq) ? r1 : r2;
  assign raddr_b = (op == OpBeq) ? r2 : ((op == OpSt) ? r1 : r3);
  assign rf_wdata = (op == OpLd) ? mdr_q : alu_q;

  mc_regfile #(
    .DATA_W (DATA_W),
    .AW     (REG_AW)
  ) u_regfile (
    .clk_i     (clk),
    .rst_i     (reset),
    .raddr_a_i (raddr_a),
    .rdata_a_o (rdata_a),
    .raddr_b_i (raddr_b),
    .rdata_b_o (rdata_b),
    .we_i      (rf_we),
    .waddr_i   (r1),
    .wdata_i   (rf_wdata)
  );

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    ir_d      = ir_q;
    a_d       = a_q;
    b_d       = b_q;
    alu_d     = alu_q;
    mdr_d     = mdr_q;
    dmem_we_d = dmem_we_q;
    rf_we     = 1'b0;
    case (state_q)
      StFetch: begin
        // The request flop gates ack, so a stray ack before the request is ignored.
        if (imem_req_q && bus.imem_ack) begin
          ir_d    = bus.imem_rdata;
          state_d = StDecode;
        end
      end
      StDecode: begin
        a_d   = rdata_a;
        b_d   = rdata_b;
        pc_d  = pc_inc;
        alu_d = DATA_W'(pc_inc) + imm_sext;  // branch target, consumed by BEQ in EXEC
        case (op)
          OpJ: begin
            pc_d    = PC_W'(ir_q[25:0]);
            state_d = StFetch;
          end
          OpHalt: state_d = StHalt;
          OpAdd, OpSub, OpAnd, OpOr, OpAddi, OpLd, OpSt, OpBeq: state_d = StExec;
          default: state_d = StFetch;
        endcase
      end
      StExec: begin
        state_d = StWb;
        case (op)
          OpAdd:  alu_d = a_q + b_q;
          OpSub:  alu_d = a_q - b_q;
          OpAnd:  alu_d = a_q & b_q;
          OpOr:   alu_d = a_q | b_q;
          OpAddi: alu_d = a_q + imm_sext;
          OpLd, OpSt: begin
            alu_d     = a_q + imm_sext;
            dmem_we_d = (op == OpSt);
            state_d   = StMem;
          end
          OpBeq: begin
            if (a_q == b_q) pc_d = PC_W'(alu_q);
            state_d = StFetch;
          end
          default: state_d = StFetch;
        endcase
      end
      StMem: begin
        if (dmem_req_q && bus.dmem_ack) begin
          if (dmem_we_q) begin
            state_d = StFetch;
          end else begin
            mdr_d   = bus.dmem_rdata;
            state_d = StWb;
          end
        end
      end
      StWb: begin
        rf_we   = 1'b1;
        state_d = StFetch;
      end
      StHalt:  state_d = StHalt;
      default: state_d = StFetch;
    endcase
    // Requests are registered copies of the next state: no ack-to-req combinational path.
    imem_req_d = (state_d == StFetch);
    dmem_req_d = (state_d == StMem);
    if (state_d != StMem) dmem_we_d = 1'b0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= StFetch;
      pc_q       <= '0;
      ir_q       <= '0;
      a_q        <= '0;
      b_q        <= '0;
      alu_q      <= '0;
      mdr_q      <= '0;
      imem_req_q <= 1'b0;
      dmem_req_q <= 1'b0;
      dmem_we_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      ir_q       <= ir_d;
      a_q        <= a_d;
      b_q        <= b_d;
      alu_q      <= alu_d;
      mdr_q      <= mdr_d;
      imem_req_q <= imem_req_d;
      dmem_req_q <= dmem_req_d;
      dmem_we_q  <= dmem_we_d;
    end
  end

  assign bus.imem_req   = imem_req_q;
  assign bus.imem_addr  = pc_q;
  assign bus.dmem_req   = dmem_req_q;
  assign bus.dmem_we    = dmem_we_q;
  assign bus.dmem_addr  = DADDR_W'(alu_q);
  assign bus.dmem_wdata = b_q;

  assign halted = (state_q == StHalt);
  assign pc     = pc_q;
  assign state  = state_q;
endmodule
